bcd_convert_seq: RTL and testbench

Parametrised, sequential binary-to-BCD converter for the clock datapath. It replaces per-field combinational conversion with one iterative double-dabble engine: one input bit per clock, any input width and digit count. It provides ready/valid handshakes on both sides, an overflow flag with saturation, and a per-digit leading-zero blank mask for the seven-segment driver.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bcd_convert_seq.sv | 152 +++++++++++++++
 tb/tb_bcd_convert_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         NIBBLE_W      = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Decimal digits needed to print the largest value of a 'width'-bit word.
    function automatic int min_digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
// Latency: combinational.
// Backpressure: none (pure function of its input).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nib_i,
    output logic [NIBBLE_W-1:0] nib_o
);

    // Pre-shift correction so the following doubling carries into the next digit.
    always_comb begin
        nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Latency: BIN_W cycles from accept to out_valid; one result per BIN_W+2 cycles.
// Backpressure: out_ready low holds DONE with frozen outputs; no input accepted until the result is taken.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_W-1:0]             in_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*DIGITS-1:0]   out_bcd,
    output logic                         out_ovf,
    output logic [DIGITS-1:0]            out_blank,
    output logic                         busy
);

    localparam int             BCD_W    = NIBBLE_W * DIGITS;
    localparam int             CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    // When DIGITS covers every representable input, overflow cannot occur.
    localparam bit             OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $fatal(1, "bcd_convert_seq: BIN_W=%0d outside 1..32", BIN_W);
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $fatal(1, "bcd_convert_seq: DIGITS=%0d outside 1..10", DIGITS);
    end

    state_t             state_q,     state_d;
    logic [BIN_W-1:0]   bin_q,       bin_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic               sticky_q,    sticky_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [BCD_W-1:0]   out_bcd_q,   out_bcd_d;
    logic               out_ovf_q,   out_ovf_d;
    logic [DIGITS-1:0]  out_blank_q, out_blank_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;
    logic [BCD_W-1:0]   nines;
    logic [BCD_W-1:0]   fin_bcd;
    logic               fin_ovf;
    logic               nib_bad;
    logic [DIGITS-1:0]  fin_blank;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_i (bcd_q[NIBBLE_W*g +: NIBBLE_W]),
            .nib_o (adj[NIBBLE_W*g +: NIBBLE_W])
        );
    end

    // One iteration's shift result plus the saturated final value seen on the last edge.
    always_comb begin
        shifted = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        nib_bad = 1'b0;
        nines   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nines[NIBBLE_W*k +: NIBBLE_W] = BCD_MAX_DIGIT;
            if (shifted[NIBBLE_W*k +: NIBBLE_W] > BCD_MAX_DIGIT) begin
                nib_bad = 1'b1;
            end
        end
        fin_ovf = OVF_POSSIBLE && (sticky_q || adj[BCD_W-1] || nib_bad);
        fin_bcd = fin_ovf ? nines : shifted;
    end

    // Leading-zero mask: digit k blanks when it and everything above it is zero.
    assign fin_blank[0] = 1'b0;
    for (genvar k = 1; k < DIGITS; k++) begin : g_blank
        assign fin_blank[k] = (fin_bcd[BCD_W-1:NIBBLE_W*k] == '0);
    end

    // Next-state and datapath updates; result registers load only on entry to DONE.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        out_bcd_d   = out_bcd_q;
        out_ovf_d   = out_ovf_q;
        out_blank_d = out_blank_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d    = in_bin;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d    = shifted;
                bin_d    = bin_q << 1;
                sticky_d = sticky_q | adj[BCD_W-1];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = DONE;
                    out_bcd_d   = fin_bcd;
                    out_ovf_d   = fin_ovf;
                    out_blank_d = fin_blank;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_blank_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            out_ovf_q   <= out_ovf_d;
            out_blank_q <= out_blank_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;
    assign out_blank = out_blank_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq across four width/digit configurations.
// Latency: checks accept-to-out_valid distance of BIN_W cycles on every conversion.
// Backpressure: holds out_ready low on one conversion and checks frozen outputs.
module tb_bcd_convert_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic [31:0] in_bin    [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic        busy      [4];
    logic        out_ovf   [4];
    logic [39:0] bcd       [4];
    logic [9:0]  blank     [4];

    logic [15:0] bcd_a;  logic [3:0] blk_a;
    logic [11:0] bcd_b;  logic [2:0] blk_b;
    logic [7:0]  bcd_c;  logic [1:0] blk_c;
    logic [19:0] bcd_d;  logic [4:0] blk_d;

    int wid [4] = '{12, 12, 6, 16};
    int dig [4] = '{4, 3, 2, 5};

    int n_tests = 0;
    int n_fail  = 0;

    bcd_convert_seq #(.BIN_W(12), .DIGITS(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bin(in_bin[0][11:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bcd(bcd_a), .out_ovf(out_ovf[0]), .out_blank(blk_a), .busy(busy[0]));
    bcd_convert_seq #(.BIN_W(12), .DIGITS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bin(in_bin[1][11:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bcd(bcd_b), .out_ovf(out_ovf[1]), .out_blank(blk_b), .busy(busy[1]));
    bcd_convert_seq #(.BIN_W(6), .DIGITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bin(in_bin[2][5:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bcd(bcd_c), .out_ovf(out_ovf[2]), .out_blank(blk_c), .busy(busy[2]));
    bcd_convert_seq #(.BIN_W(16), .DIGITS(5)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_bin(in_bin[3][15:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_bcd(bcd_d), .out_ovf(out_ovf[3]), .out_blank(blk_d), .busy(busy[3]));

    assign bcd[0] = 40'(bcd_a);  assign blank[0] = 10'(blk_a);
    assign bcd[1] = 40'(bcd_b);  assign blank[1] = 10'(blk_b);
    assign bcd[2] = 40'(bcd_c);  assign blank[2] = 10'(blk_c);
    assign bcd[3] = 40'(bcd_d);  assign blank[3] = 10'(blk_d);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, saturation at 10^d - 1.
    function automatic void model(input longint v, input int d, output logic [39:0] eb,
                                  output logic eo, output logic [9:0] el);
        longint lim;
        longint sat;
        longint r;
        longint p;
        lim = 1;
        for (int k = 0; k < d; k++) lim = lim * 10;
        eo  = (v >= lim);
        sat = eo ? lim - 1 : v;
        eb  = '0;
        el  = '0;
        r   = sat;
        for (int k = 0; k < d; k++) begin
            eb[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        p = 1;
        for (int k = 1; k < d; k++) begin
            p = p * 10;
            el[k] = (sat < p);
        end
    endfunction

    // Called and returns just after a falling edge.
    task automatic conv(input int i, input longint v, input int hold, input string tag);
        logic [39:0] eb;
        logic        eo;
        logic [9:0]  el;
        int          n;
        model(v, dig[i], eb, eo, el);
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 64'(in_ready[i]), 64'd1);
        in_bin[i]   = 32'(v);
        in_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_bin[i]   = $urandom;
        @(negedge clk);
        chk({tag, "_busy"}, 64'(busy[i]), 64'd1);
        n = 0;
        while (!out_valid[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(wid[i]));
        chk({tag, "_bcd"}, 64'(bcd[i]), 64'(eb));
        chk({tag, "_ovf"}, 64'(out_ovf[i]), 64'(eo));
        chk({tag, "_blank"}, 64'(blank[i]), 64'(el));
        for (int h = 0; h < hold; h++) begin
            in_valid[i] = 1'b1;
            in_bin[i]   = 32'd13;
            @(negedge clk);
            chk({tag, "_hold_bcd"}, 64'(bcd[i]), 64'(eb));
            chk({tag, "_hold_vld"}, 64'(out_valid[i]), 64'd1);
        end
        out_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[i] = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 64'(in_ready[i]), 64'd1);
        chk({tag, "_vld_after"}, 64'(out_valid[i]), 64'd0);
        in_valid[i] = 1'b0;
    endtask

    initial begin
        longint v;
        int     seen;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_bin[i]    = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready[0]),  64'd1);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_busy",      64'(busy[0]),      64'd0);
        chk("rst_bcd",       64'(bcd[0]),       64'd0);
        chk("rst_ovf",       64'(out_ovf[0]),   64'd0);
        chk("rst_blank",     64'(blank[0]),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        conv(0, 2024, 0, "a2024");
        conv(0, 0,    0, "a0");
        conv(0, 7,    0, "a7");
        conv(1, 1000, 0, "b1000");
        conv(1, 999,  0, "b999");
        conv(2, 59,  10, "c59hold");

        // Reset in the fifth SHIFT cycle of a conversion of 4095.
        in_bin[0]   = 32'd4095;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready",  64'(in_ready[0]),  64'd1);
        chk("mrst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("mrst_busy",      64'(busy[0]),      64'd0);
        chk("mrst_bcd",       64'(bcd[0]),       64'd0);
        chk("mrst_ovf",       64'(out_ovf[0]),   64'd0);
        chk("mrst_blank",     64'(blank[0]),     64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1;
        end
        chk("mrst_no_pulse", 64'(seen), 64'd0);
        conv(0, 59, 0, "a59");

        conv(3, 0,     0, "d0");
        conv(3, 65535, 0, "d65535");
        conv(3, 9,     0, "d9");
        conv(3, 10,    0, "d10");
        conv(3, 99,    0, "d99");
        conv(3, 100,   0, "d100");
        conv(3, 9999,  0, "d9999");
        conv(3, 10000, 0, "d10000");
        for (int r = 0; r < 1500; r++) begin
            case ($urandom_range(0, 3))
                0:       v = longint'($urandom_range(0, 120));
                1:       v = longint'($urandom_range(990, 1010));
                2:       v = longint'($urandom_range(9990, 10010));
                default: v = longint'($urandom_range(0, 65535));
            endcase
            conv(3, v, 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
